// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: CDB result type and functional-unit port bindings shared by the arbiter slice.
// Revision: 1.0
`default_nettype none

package cdb_arbiter_pkg;

  localparam int CDB_REQ_ALU = 0;
  localparam int CDB_REQ_MUL = 1;
  localparam int CDB_REQ_DIV = 2;
  localparam int CDB_REQ_MEM = 3;

  localparam int ROB_ID_W = 5;
  localparam int REG_ID_W = 5;
  localparam int XLEN     = 32;

  typedef struct packed {
    logic                ready;
    logic [ROB_ID_W-1:0] rob_id;
    logic [REG_ID_W-1:0] rd;
    logic [XLEN-1:0]     result;
  } cdb_t;

endpackage

`default_nettype wire

// File: rtl/cdb_arb_pick.sv
// cdb_arb_pick: combinational fixed-priority pick; escalated requesters pre-empt ordinary ones.
// Revision: 1.0
`default_nettype none

module cdb_arb_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] esc,
  output logic [NUM_REQ-1:0] grant
);

  logic [NUM_REQ-1:0] cand;

  always_comb begin
    cand  = (|esc) ? esc : req;
    // Isolate the lowest set bit: index 0 is highest priority.
    grant = cand & (~cand + NUM_REQ'(1));
  end

endmodule

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the common data bus among NUM_REQ units with starvation escalation.
// Optional CDB_ARBITER_PERF_EN adds per-unit saturating grant/stall counters. Revision: 1.0
`default_nettype none

module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  cdb_t               req_cdb [NUM_REQ],
  output logic [NUM_REQ-1:0] req_stall,
  output cdb_t               cdb_out
`ifdef CDB_ARBITER_PERF_EN
  ,
  output logic [31:0]        perf_grant_cnt [NUM_REQ],
  output logic [31:0]        perf_stall_cnt [NUM_REQ]
`endif
);

  localparam int              CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]   starve_cnt [NUM_REQ];
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] esc;
  logic [NUM_REQ-1:0] pick_grant;
  logic [NUM_REQ-1:0] grant;
  cdb_t               win;

  always_comb begin
    req = '0;
    esc = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req[i] = req_cdb[i].ready;
      esc[i] = req_cdb[i].ready & (starve_cnt[i] == LIMIT);
    end
  end

  cdb_arb_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (req),
    .esc   (esc),
    .grant (pick_grant)
  );

  // Nothing is taken while flushing or held in reset; every requester sees a stall.
  always_comb begin
    grant     = (flush | ~rst_n) ? '0 : pick_grant;
    req_stall = req & ~grant;
    win       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) win = req_cdb[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) starve_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (flush || !req[i] || grant[i]) starve_cnt[i] <= '0;
        else if (starve_cnt[i] != LIMIT)  starve_cnt[i] <= starve_cnt[i] + CNT_W'(1);
      end
    end
  end

  // Payload holds when idle; only the valid bit drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_out <= '0;
    end else if (|grant) begin
      cdb_out       <= win;
      cdb_out.ready <= 1'b1;
    end else begin
      cdb_out.ready <= 1'b0;
    end
  end

`ifdef CDB_ARBITER_PERF_EN
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        perf_grant_cnt[g] <= '0;
        perf_stall_cnt[g] <= '0;
      end else begin
        if (grant[g] && perf_grant_cnt[g] != '1)     perf_grant_cnt[g] <= perf_grant_cnt[g] + 32'd1;
        if (req_stall[g] && perf_stall_cnt[g] != '1) perf_stall_cnt[g] <= perf_stall_cnt[g] + 32'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed stimulus with a queue-based scoreboard on cdb_out broadcasts.
// Revision: 1.0
`default_nettype none

module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int NUM_REQ = 4;

  logic               clk;
  logic               rst_n;
  logic               flush;
  cdb_t               req_cdb [NUM_REQ];
  logic [NUM_REQ-1:0] req_stall;
  cdb_t               cdb_out;
`ifdef CDB_ARBITER_PERF_EN
  logic [31:0]        perf_grant_cnt [NUM_REQ];
  logic [31:0]        perf_stall_cnt [NUM_REQ];
`endif

  int   n_cmp = 0;
  int   n_bad = 0;
  cdb_t exp_q [$];

  cdb_arbiter #(.NUM_REQ(NUM_REQ), .STARVE_LIMIT(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .req_cdb   (req_cdb),
    .req_stall (req_stall),
    .cdb_out   (cdb_out)
`ifdef CDB_ARBITER_PERF_EN
    ,
    .perf_grant_cnt (perf_grant_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic cdb_t mk(input logic [4:0] rob, input logic [4:0] rd, input logic [31:0] res);
    cdb_t c;
    c.ready  = 1'b1;
    c.rob_id = rob;
    c.rd     = rd;
    c.result = res;
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NUM_REQ; i++) req_cdb[i] = '0;
  endtask

  // Monitor: every broadcast seen on cdb_out must match the head of the scoreboard.
  initial begin
    cdb_t e;
    forever begin
      @(negedge clk);
      if (cdb_out.ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_bcast: got %h expected none (t=%0t)", cdb_out, $time);
        end else begin
          e = exp_q.pop_front();
          check("bcast", 64'(cdb_out), 64'(e));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    clear_reqs();
    req_cdb[1] = mk(5'd9, 5'd9, 32'h9);
    #2;
    check("reset_out", 64'(cdb_out), 64'd0);
    check("reset_stall", 64'(req_stall), 64'b0010);
    clear_reqs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester, one-cycle latency, payload held after.
    step();
    req_cdb[2] = mk(5'd5, 5'd3, 32'hDEAD);
    #1 check("single_stall", 64'(req_stall), 64'b0000);
    exp_q.push_back(mk(5'd5, 5'd3, 32'hDEAD));
    step();
    clear_reqs();
    step();
    check("idle_ready", 64'(cdb_out.ready), 64'd0);
    check("idle_hold", 64'(cdb_out.result), 64'hDEAD);

    // Units 0 and 3 together: 0 first, then 3.
    req_cdb[0] = mk(5'd1, 5'd1, 32'h100);
    req_cdb[3] = mk(5'd3, 5'd4, 32'h300);
    #1 check("pair_stall0", 64'(req_stall), 64'b1000);
    exp_q.push_back(mk(5'd1, 5'd1, 32'h100));
    step();
    req_cdb[0] = '0;
    #1 check("pair_stall1", 64'(req_stall), 64'b0000);
    exp_q.push_back(mk(5'd3, 5'd4, 32'h300));
    step();
    clear_reqs();

    // Starvation: unit 1 loses 8 times to unit 0, wins on the 9th.
    req_cdb[0] = mk(5'hA, 5'd2, 32'hA0);
    req_cdb[1] = mk(5'hB, 5'd5, 32'hB0);
    for (int k = 1; k <= 8; k++) begin
      #1 check("starve_stall", 64'(req_stall), 64'b0010);
      exp_q.push_back(mk(5'hA, 5'd2, 32'hA0));
      step();
    end
    #1 check("escalate_stall", 64'(req_stall), 64'b0001);
    exp_q.push_back(mk(5'hB, 5'd5, 32'hB0));
    step();
    check("starve_cnt_clr", 64'(dut.starve_cnt[1]), 64'd0);
    clear_reqs();
    step();

    // Flush with a broadcast in flight and a would-be loser present.
    req_cdb[0] = mk(5'd2, 5'd6, 32'h200);
    req_cdb[3] = mk(5'd4, 5'd7, 32'h400);
    exp_q.push_back(mk(5'd2, 5'd6, 32'h200));
    step();
    req_cdb[3] = '0;
    req_cdb[1] = mk(5'd6, 5'd8, 32'h600);
    flush = 1'b1;
    #1 check("flush_stall", 64'(req_stall), 64'b0011);
    step();
    flush = 1'b0;
    clear_reqs();
    check("flush_ready", 64'(cdb_out.ready), 64'd0);
    for (int i = 0; i < NUM_REQ; i++) check("flush_starve", 64'(dut.starve_cnt[i]), 64'd0);

    // Asynchronous reset with a broadcast on the bus.
    step();
    req_cdb[2] = mk(5'd7, 5'd1, 32'hBEEF);
    step();
    clear_reqs();
    check("pre_reset_ready", 64'(cdb_out.ready), 64'd1);
    rst_n = 1'b0;
    #1 check("async_reset", 64'(cdb_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef CDB_ARBITER_PERF_EN
    step();
    req_cdb[0] = mk(5'd1, 5'd1, 32'h1);
    req_cdb[1] = mk(5'd2, 5'd2, 32'h2);
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(mk(5'd1, 5'd1, 32'h1));
      step();
    end
    req_cdb[0] = '0;
    for (int k = 0; k < 10; k++) begin
      exp_q.push_back(mk(5'd2, 5'd2, 32'h2));
      step();
    end
    clear_reqs();
    check("perf_grant1", 64'(perf_grant_cnt[1]), 64'd10);
    check("perf_stall1", 64'(perf_stall_cnt[1]), 64'd3);
    check("perf_grant0", 64'(perf_grant_cnt[0]), 64'd3);
`endif

    step();
    step();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
